mul_div_unit: RTL

Multi-cycle RV32M multiply/divide execution unit. It consumes the two source operands read from the register file together with the destination index. It produces a single write-back transaction (index, data, write strobe) that drives the register file write port directly. While it computes, `busy` tells the control unit to stall issue.

---
 rtl/mul_div_unit_if.sv | 34 +++
 rtl/mul_div_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_div_unit_if                                              |
// | Description : Issue / write-back bundle between control, register file     |
// |               and the RV32M multiply/divide unit.                          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface mul_div_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operandA;
  logic [XLEN-1:0] operandB;
  logic [4:0]      rdIn;
  logic            busy;
  logic            done;
  logic            writeRegister;
  logic [4:0]      rdOut;
  logic [XLEN-1:0] result;

  // Control / issue side
  modport master (
    output start, funct3, operandA, operandB, rdIn,
    input  busy, done, writeRegister, rdOut, result
  );

  // Execution unit side
  modport slave (
    input  start, funct3, operandA, operandB, rdIn,
    output busy, done, writeRegister, rdOut, result
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_div_unit                                                 |
// | Description : Multi-cycle RV32M multiply/divide unit (shift-add multiply,  |
// |               restoring divide). Define MULDIV_FAST_MUL_EN for a           |
// |               single-cycle combinational multiplier.                       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  wire logic       clock,
  input  wire logic       reset,
  mul_div_unit_if.slave   bus
);

  localparam int          c_W2       = 2 * XLEN;
  localparam logic [4:0]  c_LAST_ITR = 5'd31;
  localparam logic [XLEN-1:0] c_ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [4:0]      r_count;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_divisor;
  logic            r_neg;
  logic [c_W2-1:0] r_acc;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;
  logic            r_busy;
  logic            r_done;

  // ---------------- launch decode ----------------
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_launch_neg;
  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_special_result;

  assign w_is_div   = bus.funct3[2];
  assign w_a_signed = w_is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~bus.funct3[0] : ~bus.funct3[1];
  assign w_a_neg    = w_a_signed & bus.operandA[XLEN-1];
  assign w_b_neg    = w_b_signed & bus.operandB[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~bus.operandA + 1'b1) : bus.operandA;
  assign w_b_mag    = w_b_neg ? (~bus.operandB + 1'b1) : bus.operandB;

  // Remainder follows the dividend; everything else follows the sign product.
  assign w_launch_neg = (w_is_div & bus.funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_zero = w_is_div & (bus.operandB == '0);
  assign w_overflow = w_is_div & ~bus.funct3[0] &
                      (bus.operandA == c_MIN_NEG) & (bus.operandB == c_ALL_ONES);

  always_comb begin
    w_special_result = '0;
    if (w_div_zero)
      w_special_result = bus.funct3[1] ? bus.operandA : c_ALL_ONES;
    else if (w_overflow)
      w_special_result = bus.funct3[1] ? '0 : c_MIN_NEG;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]   w_fast_a;
  logic signed [XLEN:0]   w_fast_b;
  logic        [c_W2-1:0] w_fast_prod;
  logic        [XLEN-1:0] w_fast_result;

  assign w_fast_a      = {w_a_signed & bus.operandA[XLEN-1], bus.operandA};
  assign w_fast_b      = {w_b_signed & bus.operandB[XLEN-1], bus.operandB};
  assign w_fast_prod   = c_W2'(w_fast_a * w_fast_b);
  assign w_fast_result = (bus.funct3[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0]
                                                    : w_fast_prod[c_W2-1:XLEN];
`endif

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]   w_mul_sum;
  logic [c_W2-1:0] w_mul_next;
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [c_W2-1:0] w_div_next;
  logic [c_W2-1:0] w_acc_next;

  // Product register shifts right; the carry of the add becomes the new MSB.
  assign w_mul_sum  = {1'b0, r_acc[c_W2-1:XLEN]} + {1'b0, (r_acc[0] ? r_divisor : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring step: the shifted partial remainder is 33 bits wide.
  assign w_rem_sh   = {r_acc[c_W2-1:XLEN], r_acc[XLEN-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_divisor});
  assign w_diff     = w_rem_sh[XLEN-1:0] - r_divisor;
  assign w_div_next = w_ge ? {w_diff,               r_acc[XLEN-2:0], 1'b1}
                           : {w_rem_sh[XLEN-1:0],   r_acc[XLEN-2:0], 1'b0};

  assign w_acc_next = r_funct3[2] ? w_div_next : w_mul_next;

  // ---------------- sign correction / result select ----------------
  logic [c_W2-1:0] w_prod_fix;
  logic [XLEN-1:0] w_quot_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_final;

  assign w_prod_fix = r_neg ? (~w_mul_next + 1'b1) : w_mul_next;
  assign w_quot_fix = r_neg ? (~w_div_next[XLEN-1:0] + 1'b1) : w_div_next[XLEN-1:0];
  assign w_rem_fix  = r_neg ? (~w_div_next[c_W2-1:XLEN] + 1'b1) : w_div_next[c_W2-1:XLEN];

  always_comb begin
    w_final = '0;
    case (r_funct3)
      3'b000:                 w_final = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_fix[c_W2-1:XLEN];
      3'b100, 3'b101:         w_final = w_quot_fix;
      default:                w_final = w_rem_fix;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_divisor <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_result  <= '0;
      r_rd_out  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_funct3  <= bus.funct3;
            r_rd      <= bus.rdIn;
            r_divisor <= w_b_mag;
            r_acc     <= {{XLEN{1'b0}}, w_a_mag};
            r_neg     <= w_launch_neg;
            r_count   <= '0;
            r_busy    <= 1'b1;
            if (w_div_zero | w_overflow) begin
              r_result <= w_special_result;
              r_rd_out <= bus.rdIn;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!w_is_div) begin
              r_result <= w_fast_result;
              r_rd_out <= bus.rdIn;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
`endif
            else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + 5'd1;
          if (r_count == c_LAST_ITR) begin
            r_result <= w_final;
            r_rd_out <= r_rd;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.writeRegister = r_done;
  assign bus.rdOut         = r_rd_out;
  assign bus.result        = r_result;

endmodule
`default_nettype wire
